ahb_extsram_sub: RTL and testbench

- AHB-Lite subordinate occupying the EXT_MEM window (base 0x80000000).
- Serves Wally's 32-bit bus manager (AHBW = 32) by translating each AHB transfer into one or two 16-bit accesses on the DE2-115 asynchronous SRAM (1M x 16).
- Sits in the uncore beside the other subordinates; the board top instantiates the DQ tristate buffer.

---
 rtl/ahb_extsram_sub.sv | 162 ++++++++++++++++
 tb/tb_ahb_extsram_sub.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_extsram_sub.sv
// AHB-Lite subordinate for the external 16-bit asynchronous SRAM window.
// A 32-bit transfer becomes one or two timed halfword accesses (LO then HI).
// Ports: clk/reset (sync, active-high); AHB-Lite subordinate side: HSEL, HADDR,
//        HWRITE, HSIZE, HTRANS, HWDATA, HWSTRB, HREADY -> HRDATA, HREADYOUT, HRESP;
//        SRAM pad side: SRAM_ADDR, SRAM_DQ_IN/OUT/OE, SRAM_CE_N/OE_N/WE_N/UB_N/LB_N.
module ahb_extsram_sub #(
    parameter int unsigned ADDR_BITS   = 20,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 HSEL,
    input  logic [31:0]          HADDR,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [1:0]           HTRANS,
    input  logic [31:0]          HWDATA,
    input  logic [3:0]           HWSTRB,
    input  logic                 HREADY,
    output logic [31:0]          HRDATA,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [ADDR_BITS-1:0] SRAM_ADDR,
    input  logic [15:0]          SRAM_DQ_IN,
    output logic [15:0]          SRAM_DQ_OUT,
    output logic                 SRAM_DQ_OE,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_OE_N,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N
);

    localparam int unsigned IDX_W = ADDR_BITS - 1;
    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_RESP} state_t;

    state_t           state_q, state_d;
    logic             wdec_q, wdec_d;       // first data-phase cycle of a write
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             write_q, write_d;
    logic             hi_need_q, hi_need_d; // read only; writes use strobes
    logic [3:0]       wstrb_q, wstrb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hrdata_q, hrdata_d;
    logic             hready_q, hready_d;

    state_t           act_c;                // half actually being accessed this cycle
    logic [3:0]       strb_c;
    logic             hi_need_c;
    logic             in_half_c;
    logic             last_c;
    logic             cap_c;
    logic             unused_c;

    assign unused_c = ^{HADDR[31:ADDR_BITS+1], HADDR[0], HTRANS[0]};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wdec_q    <= 1'b0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            hi_need_q <= 1'b0;
            wstrb_q   <= 4'h0;
            cnt_q     <= '0;
            hrdata_q  <= 32'h0;
            hready_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            wdec_q    <= wdec_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            hi_need_q <= hi_need_d;
            wstrb_q   <= wstrb_d;
            cnt_q     <= cnt_d;
            hrdata_q  <= hrdata_d;
            hready_q  <= hready_d;
        end
    end

    // Next-state, capture and read-data sampling
    always_comb begin
        state_d   = state_q;
        wdec_d    = 1'b0;
        idx_d     = idx_q;
        write_d   = write_q;
        hi_need_d = hi_need_q;
        wstrb_d   = wstrb_q;
        cnt_d     = cnt_q;
        hrdata_d  = hrdata_q;

        // Write strobes arrive a cycle after capture; the first data cycle
        // picks the half directly from HWSTRB so no extra cycle is spent.
        strb_c = wdec_q ? HWSTRB : wstrb_q;
        if (wdec_q) begin
            wstrb_d = HWSTRB;
        end
        act_c = state_q;
        if (wdec_q) begin
            if (|HWSTRB[1:0])      act_c = ST_LO;
            else if (|HWSTRB[3:2]) act_c = ST_HI;
            else                   act_c = ST_IDLE;
        end

        hi_need_c = write_q ? (|strb_c[3:2]) : hi_need_q;
        in_half_c = (act_c == ST_LO) || (act_c == ST_HI);
        last_c    = (cnt_q == CNT_W'(WAIT_CYCLES));
        cap_c     = HSEL && HREADY && HTRANS[1]
                    && ((state_q == ST_IDLE) || (state_q == ST_RESP));

        if (in_half_c) begin
            if (last_c) begin
                cnt_d = '0;
                if (!write_q) begin
                    if (act_c == ST_HI) hrdata_d[31:16] = SRAM_DQ_IN;
                    else                hrdata_d[15:0]  = SRAM_DQ_IN;
                end
                state_d = ((act_c == ST_LO) && hi_need_c) ? ST_HI : ST_RESP;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = act_c;
            end
        end else if (wdec_q) begin
            // null write: no lanes enabled
            state_d = ST_RESP;
        end else if (cap_c) begin
            idx_d    = HADDR[ADDR_BITS:2];
            write_d  = HWRITE;
            hrdata_d = 32'h0;
            cnt_d    = '0;
            if (HWRITE) begin
                wdec_d  = 1'b1;
                state_d = ST_LO;
            end else begin
                hi_need_d = (HSIZE >= 3'd2) || HADDR[1];
                state_d   = ((HSIZE >= 3'd2) || !HADDR[1]) ? ST_LO : ST_HI;
            end
        end else begin
            state_d = ST_IDLE;
        end

        hready_d = (state_d == ST_IDLE) || (state_d == ST_RESP);
    end

    // SRAM pad controls follow the half being accessed
    assign SRAM_CE_N   = !in_half_c;
    assign SRAM_ADDR   = in_half_c ? {idx_q, (act_c == ST_HI)} : '0;
    assign SRAM_OE_N   = !(in_half_c && !write_q);
    assign SRAM_DQ_OE  = in_half_c && write_q;
    assign SRAM_WE_N   = !(in_half_c && write_q && (cnt_q != '0));
    assign SRAM_DQ_OUT = (act_c == ST_HI) ? HWDATA[31:16] : HWDATA[15:0];
    assign SRAM_UB_N   = !in_half_c || (write_q && !((act_c == ST_HI) ? strb_c[3] : strb_c[1]));
    assign SRAM_LB_N   = !in_half_c || (write_q && !((act_c == ST_HI) ? strb_c[2] : strb_c[0]));

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hready_q;
    assign HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb_extsram_sub.sv
// Directed bench for ahb_extsram_sub with a behavioural SRAM and a read scoreboard.
module tb_ahb_extsram_sub;

    localparam int unsigned AB = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [1:0]    HTRANS;
    logic [31:0]   HWDATA;
    logic [3:0]    HWSTRB;
    logic          HREADY;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [AB-1:0] SRAM_ADDR;
    logic [15:0]   SRAM_DQ_IN;
    logic [15:0]   SRAM_DQ_OUT;
    logic          SRAM_DQ_OE;
    logic          SRAM_CE_N;
    logic          SRAM_OE_N;
    logic          SRAM_WE_N;
    logic          SRAM_UB_N;
    logic          SRAM_LB_N;

    always #5 clk = ~clk;
    assign HREADY = HREADYOUT;

    ahb_extsram_sub #(.ADDR_BITS(AB), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
        .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_IN(SRAM_DQ_IN), .SRAM_DQ_OUT(SRAM_DQ_OUT),
        .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    // Behavioural SRAM (low 256 halfwords are enough here)
    logic [15:0] mem [0:255];
    always_comb SRAM_DQ_IN = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[7:0]] : 16'h0000;
    always @(posedge clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_OE) begin
            if (!SRAM_LB_N) mem[SRAM_ADDR[7:0]][7:0]  <= SRAM_DQ_OUT[7:0];
            if (!SRAM_UB_N) mem[SRAM_ADDR[7:0]][15:8] <= SRAM_DQ_OUT[15:8];
        end
    end

    // Free-running pin activity counters; the bench diffs snapshots
    int   ce_lo = 0, ce_hi = 0, we_cyc = 0, we_pulses = 0, overlap_cnt = 0;
    logic prev_we = 1'b1;
    logic last_ub = 1'b1, last_lb = 1'b1;
    always @(negedge clk) begin
        if (!SRAM_CE_N) begin
            if (SRAM_ADDR[0]) ce_hi <= ce_hi + 1;
            else              ce_lo <= ce_lo + 1;
        end
        if (!SRAM_WE_N) begin
            we_cyc  <= we_cyc + 1;
            last_ub <= SRAM_UB_N;
            last_lb <= SRAM_LB_N;
            if (prev_we) we_pulses <= we_pulses + 1;
        end
        if (SRAM_DQ_OE && !SRAM_OE_N) overlap_cnt <= overlap_cnt + 1;
        prev_we <= SRAM_WE_N;
    end

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_q[$];
    logic          cur_wr;
    int            s_lo, s_hi, s_wc, s_wp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive an address phase in the current (ready) cycle
    task automatic addr_ph(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                           input logic [31:0] exp_rd);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = a;
        HWRITE = wr;
        HSIZE  = sz;
        cur_wr = wr;
        if (!wr) exp_q.push_back(exp_rd);
        s_lo = ce_lo; s_hi = ce_hi; s_wc = we_cyc; s_wp = we_pulses;
    endtask

    // Data phase: returns in the first cycle with HREADYOUT = 1
    task automatic data_ph(input string tag, input logic [31:0] wd, input logic [3:0] ws,
                           input int exp_lat);
        int          cyc;
        logic [31:0] e;
        @(posedge clk); #1;
        HWDATA = wd; HWSTRB = ws; HSEL = 1'b0; HTRANS = 2'b00;
        cyc = 1;
        while (!HREADYOUT && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        if (!cur_wr) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
            chk({tag, "_rdata"}, HRDATA, e);
        end
    endtask

    initial begin
        int cyc;
        reset = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 3'd2;
        HTRANS = 2'b00; HWDATA = 32'h0; HWSTRB = 4'h0; cur_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hready", 32'(HREADYOUT), 32'h1);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_hresp", 32'(HRESP), 32'h0);
        chk("rst_strobes", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1f);
        chk("rst_dq_oe", 32'(SRAM_DQ_OE), 32'h0);
        chk("rst_addr", 32'(SRAM_ADDR), 32'h0);
        reset = 1'b0;

        // Word write then word read
        addr_ph(32'h8000_0010, 1'b1, 3'd2, 32'h0);
        data_ph("wr_word", 32'hDEAD_BEEF, 4'hF, 5);
        chk("mem8", 32'(mem[8]), 32'h0000_BEEF);
        chk("mem9", 32'(mem[9]), 32'h0000_DEAD);
        chk("wr_word_we_cyc", 32'(we_cyc - s_wc), 32'd2);
        chk("wr_word_we_pulses", 32'(we_pulses - s_wp), 32'd2);
        addr_ph(32'h8000_0010, 1'b0, 3'd2, 32'hDEAD_BEEF);
        data_ph("rd_word", 32'h0, 4'h0, 5);

        // Byte write into the top lane
        addr_ph(32'h8000_0013, 1'b1, 3'd0, 32'h0);
        data_ph("wr_byte", 32'hA500_0000, 4'h8, 3);
        chk("wr_byte_lo_acc", 32'(ce_lo - s_lo), 32'd0);
        chk("wr_byte_hi_acc", 32'(ce_hi - s_hi), 32'd2);
        chk("wr_byte_ub_n", 32'(last_ub), 32'h0);
        chk("wr_byte_lb_n", 32'(last_lb), 32'h1);
        addr_ph(32'h8000_0010, 1'b0, 3'd2, 32'hA5AD_BEEF);
        data_ph("rd_after_byte", 32'h0, 4'h0, 5);

        // Single-half reads and address aliasing
        addr_ph(32'h8000_0010, 1'b0, 3'd1, 32'h0000_BEEF);
        data_ph("rd_half_lo", 32'h0, 4'h0, 3);
        chk("rd_half_lo_hi_acc", 32'(ce_hi - s_hi), 32'd0);
        addr_ph(32'h8000_0012, 1'b0, 3'd1, 32'hA5AD_0000);
        data_ph("rd_half_hi", 32'h0, 4'h0, 3);
        chk("rd_half_hi_lo_acc", 32'(ce_lo - s_lo), 32'd0);
        addr_ph(32'h8000_0011, 1'b0, 3'd0, 32'h0000_BEEF);
        data_ph("rd_byte", 32'h0, 4'h0, 3);
        addr_ph(32'h9000_0010, 1'b0, 3'd2, 32'hA5AD_BEEF);
        data_ph("rd_alias", 32'h0, 4'h0, 5);

        // Back-to-back: read, then write captured in the read's RESP cycle
        addr_ph(32'h8000_0010, 1'b0, 3'd2, 32'hA5AD_BEEF);
        data_ph("b2b_rd", 32'h0, 4'h0, 5);
        addr_ph(32'h8000_0020, 1'b1, 3'd2, 32'h0);
        data_ph("b2b_wr", 32'h1234_5678, 4'hF, 5);
        addr_ph(32'h8000_0020, 1'b0, 3'd2, 32'h1234_5678);
        data_ph("b2b_rdback", 32'h0, 4'h0, 5);
        chk("dq_oe_overlap", 32'(overlap_cnt), 32'd0);

        // IDLE transfer with HSEL high, then a null write
        HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h8000_0010; HWRITE = 1'b0;
        s_lo = ce_lo; s_hi = ce_hi;
        @(posedge clk); #1;
        chk("idle_hready_1", 32'(HREADYOUT), 32'h1);
        @(posedge clk); #1;
        chk("idle_hready_2", 32'(HREADYOUT), 32'h1);
        HSEL = 1'b0;
        chk("idle_no_ce", 32'((ce_lo - s_lo) + (ce_hi - s_hi)), 32'd0);
        addr_ph(32'h8000_0030, 1'b1, 3'd2, 32'h0);
        data_ph("null_wr", 32'hFFFF_FFFF, 4'h0, 2);
        chk("null_wr_no_ce", 32'((ce_lo - s_lo) + (ce_hi - s_hi)), 32'd0);

        // Reset while WE_N is low
        addr_ph(32'h8000_0040, 1'b1, 3'd2, 32'h0);
        @(posedge clk); #1;
        HWDATA = 32'hCAFE_F00D; HWSTRB = 4'hF; HSEL = 1'b0; HTRANS = 2'b00;
        cyc = 0;
        while (SRAM_WE_N && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_mid_we_low", 32'(SRAM_WE_N), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_we_n", 32'(SRAM_WE_N), 32'h1);
        chk("rst_mid_ce_n", 32'(SRAM_CE_N), 32'h1);
        chk("rst_mid_dq_oe", 32'(SRAM_DQ_OE), 32'h0);
        chk("rst_mid_hready", 32'(HREADYOUT), 32'h1);
        chk("rst_mid_hrdata", HRDATA, 32'h0);
        reset = 1'b0;

        // Recovery read
        addr_ph(32'h8000_0010, 1'b0, 3'd2, 32'hA5AD_BEEF);
        data_ph("rd_after_rst", 32'h0, 4'h0, 5);
        chk("dq_oe_overlap_end", 32'(overlap_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
